// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - multi-product vending controller: coin credit, product selection, dispense and change
// All outputs are registered; next-state and next-output values are formed combinationally below.
module vend_controller #(
    parameter int WIDTH   = 8,
    parameter int NUM_SEL = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 20,
    parameter int CNT_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     coin_valid,
    input  logic [WIDTH-1:0]         coin_val,
    input  logic                     sel_valid,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SEL*WIDTH-1:0] prices,
    input  logic                     cancel,
    output logic [WIDTH-1:0]         total,
    output logic                     disp,
    output logic [SEL_W-1:0]         disp_sel,
    output logic                     change_valid,
    output logic [WIDTH-1:0]         change_amt,
    output logic                     coin_reject,
    output logic                     sel_err,
    output logic                     busy
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] DISPENSE = 2'd2;
    localparam logic [1:0] CHANGE   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [WIDTH-1:0] total_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] cnt_step;
    logic [SEL_W-1:0] disp_sel_nx;
    logic             coin_reject_nx;
    logic             sel_err_nx;
    logic [WIDTH-1:0] price;
    logic             sel_ok;
    logic             sel_accept;
    logic [WIDTH:0]   sum;
    logic             in_collect;

    always_comb begin
        price = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (sel == i[SEL_W-1:0]) begin
                price = prices[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_ok     = (32'(sel) < NUM_SEL);
    assign sel_accept = sel_ok && (total >= price);
    assign sum        = {1'b0, total} + {1'b0, coin_val};
    assign in_collect = (state == COLLECT);

    // Holding at the last value lets a refused selection on the expiry cycle defer the timeout by one cycle.
    assign cnt_step = (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_nx       = state;
        total_nx       = total;
        cnt_nx         = '0;
        disp_sel_nx    = disp_sel;
        coin_reject_nx = 1'b0;
        sel_err_nx     = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (cancel) begin
                    coin_reject_nx = coin_valid;
                    if (in_collect) begin
                        state_nx = CHANGE;
                    end
                end else if (sel_valid) begin
                    coin_reject_nx = coin_valid;
                    if (sel_accept) begin
                        total_nx    = total - price;
                        disp_sel_nx = sel;
                        state_nx    = DISPENSE;
                    end else begin
                        sel_err_nx = 1'b1;
                        if (in_collect) begin
                            cnt_nx = cnt_step;
                        end
                    end
                end else if (in_collect && (cnt == CNT_LAST)) begin
                    coin_reject_nx = coin_valid;
                    state_nx       = CHANGE;
                end else if (coin_valid) begin
                    if (sum[WIDTH]) begin
                        coin_reject_nx = 1'b1;
                        if (in_collect) begin
                            cnt_nx = cnt_step;
                        end
                    end else begin
                        total_nx = sum[WIDTH-1:0];
                        state_nx = COLLECT;
                    end
                end else if (in_collect) begin
                    cnt_nx = cnt_step;
                end
            end
            DISPENSE: begin
                coin_reject_nx = coin_valid;
                sel_err_nx     = sel_valid;
                state_nx       = (total != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                coin_reject_nx = coin_valid;
                sel_err_nx     = sel_valid;
                total_nx       = '0;
                state_nx       = IDLE;
            end
            default: begin
                total_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            total        <= '0;
            cnt          <= '0;
            disp         <= 1'b0;
            disp_sel     <= '0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            coin_reject  <= 1'b0;
            sel_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            total        <= total_nx;
            cnt          <= cnt_nx;
            disp         <= (state_nx == DISPENSE);
            disp_sel     <= disp_sel_nx;
            change_valid <= (state_nx == CHANGE);
            change_amt   <= (state_nx == CHANGE) ? total_nx : '0;
            coin_reject  <= coin_reject_nx;
            sel_err      <= sel_err_nx;
            busy         <= (state_nx == DISPENSE) || (state_nx == CHANGE);
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - self-checking bench for vend_controller with an event-queue reference model
module tb_vend_controller;

    localparam int WIDTH   = 8;
    localparam int NUM_SEL = 4;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 20;
    localparam int CNT_W   = 5;

    localparam int EV_NONE = 0;
    localparam int EV_DISP = 1;
    localparam int EV_CHG  = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     coin_valid = 1'b0;
    logic [WIDTH-1:0]         coin_val = '0;
    logic                     sel_valid = 1'b0;
    logic [SEL_W-1:0]         sel = '0;
    logic [NUM_SEL*WIDTH-1:0] prices = '0;
    logic                     cancel = 1'b0;
    logic [WIDTH-1:0]         total;
    logic                     disp;
    logic [SEL_W-1:0]         disp_sel;
    logic                     change_valid;
    logic [WIDTH-1:0]         change_amt;
    logic                     coin_reject;
    logic                     sel_err;
    logic                     busy;

    vend_controller #(
        .WIDTH(WIDTH), .NUM_SEL(NUM_SEL), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel(sel), .prices(prices), .cancel(cancel),
        .total(total), .disp(disp), .disp_sel(disp_sel), .change_valid(change_valid),
        .change_amt(change_amt), .coin_reject(coin_reject), .sel_err(sel_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int price_tab[NUM_SEL];
    int credit, since, last_sel, showing;
    bit open;
    int sched[$];
    int exp_total, exp_amt, exp_disp_sel;
    bit exp_disp, exp_cv, exp_cr, exp_se, exp_busy;

    task automatic load_prices(input int p0, input int p1, input int p2, input int p3);
        price_tab[0] = p0; price_tab[1] = p1; price_tab[2] = p2; price_tab[3] = p3;
        for (int i = 0; i < NUM_SEL; i++) prices[i*WIDTH +: WIDTH] = price_tab[i][WIDTH-1:0];
    endtask

    task automatic model_reset();
        credit = 0; since = 0; last_sel = 0; showing = EV_NONE; open = 0;
        sched.delete();
    endtask

    // Session-level model: a customer interaction produces a queue of visible events, one per cycle.
    task automatic model_step(input bit cv, input int cval, input bit sv, input int s, input bit cn);
        bit cr;
        bit se;
        cr = 0;
        se = 0;
        if (showing != EV_NONE) begin
            cr = cv;
            se = sv;
            if (showing == EV_CHG) credit = 0;
        end else if (cn) begin
            cr = cv;
            if (open) begin
                open = 0;
                sched.push_back(EV_CHG);
            end
        end else if (sv) begin
            cr = cv;
            if (s < NUM_SEL && credit >= price_tab[s]) begin
                credit = credit - price_tab[s];
                open = 0;
                last_sel = s;
                sched.push_back(EV_DISP);
                if (credit > 0) sched.push_back(EV_CHG);
            end else begin
                se = 1;
                if (open) since++;
            end
        end else if (open && since + 1 >= TIMEOUT) begin
            cr = cv;
            open = 0;
            sched.push_back(EV_CHG);
        end else if (cv) begin
            if (credit + cval > (1 << WIDTH) - 1) begin
                cr = 1;
                if (open) since++;
            end else begin
                credit = credit + cval;
                open = 1;
                since = 0;
            end
        end else if (open) begin
            since++;
        end
        showing = (sched.size() > 0) ? sched.pop_front() : EV_NONE;
        exp_total    = credit;
        exp_disp     = (showing == EV_DISP);
        exp_disp_sel = last_sel;
        exp_cv       = (showing == EV_CHG);
        exp_amt      = (showing == EV_CHG) ? credit : 0;
        exp_cr       = cr;
        exp_se       = se;
        exp_busy     = (showing != EV_NONE);
    endtask

    task automatic drive(input bit cv, input int cval, input bit sv, input int s, input bit cn);
        coin_valid = cv;
        coin_val   = cval[WIDTH-1:0];
        sel_valid  = sv;
        sel        = s[SEL_W-1:0];
        cancel     = cn;
        @(posedge clk);
        model_step(cv, cval, sv, s, cn);
        #1;
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel     = 1'b0;
    endtask

    task automatic do_reset();
        coin_valid = 1'b0; coin_val = '0; sel_valid = 1'b0; sel = '0; cancel = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({total, disp, disp_sel, change_valid, change_amt, coin_reject, sel_err, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0",
                     {total, disp, disp_sel, change_valid, change_amt, coin_reject, sel_err, busy});
        end
    endtask

    task automatic test_exact_price();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            drive(1, 25, 0, 0, 0);
            checks++;
            if (total !== 8'(25 * k)) begin
                failures++;
                $display("FAIL exact_credit%0d got=%0d required=%0d", k, total, 25 * k);
            end
        end
        drive(0, 0, 1, 1, 0);
        checks++;
        if ({disp, disp_sel, total, busy, change_valid} !== {1'b1, 2'd1, 8'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL exact_dispense got=%b required=%b", {disp, disp_sel, total, busy, change_valid},
                     {1'b1, 2'd1, 8'd0, 1'b1, 1'b0});
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({disp, change_valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL exact_no_change got=%b required=000", {disp, change_valid, busy});
        end
    endtask

    task automatic test_change();
        do_reset();
        drive(1, 100, 0, 0, 0);
        drive(1, 50, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        checks++;
        if ({disp, disp_sel, total} !== {1'b1, 2'd0, 8'd100}) begin
            failures++;
            $display("FAIL change_dispense got=%b required=%b", {disp, disp_sel, total}, {1'b1, 2'd0, 8'd100});
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({disp, change_valid, change_amt, busy} !== {1'b0, 1'b1, 8'd100, 1'b1}) begin
            failures++;
            $display("FAIL change_pulse got=%b required=%b", {disp, change_valid, change_amt, busy},
                     {1'b0, 1'b1, 8'd100, 1'b1});
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({change_valid, change_amt, total, busy} !== '0) begin
            failures++;
            $display("FAIL change_idle got=%b required=0", {change_valid, change_amt, total, busy});
        end
    endtask

    task automatic test_sel_err_cancel();
        do_reset();
        drive(1, 25, 0, 0, 0);
        drive(0, 0, 1, 2, 0);
        checks++;
        if ({sel_err, disp, total} !== {1'b1, 1'b0, 8'd25}) begin
            failures++;
            $display("FAIL selerr_pulse got=%b required=%b", {sel_err, disp, total}, {1'b1, 1'b0, 8'd25});
        end
        drive(0, 0, 0, 0, 1);
        checks++;
        if ({change_valid, change_amt, sel_err} !== {1'b1, 8'd25, 1'b0}) begin
            failures++;
            $display("FAIL cancel_refund got=%b required=%b", {change_valid, change_amt, sel_err},
                     {1'b1, 8'd25, 1'b0});
        end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(1, 200, 0, 0, 0);
        drive(1, 100, 0, 0, 0);
        checks++;
        if ({coin_reject, total} !== {1'b1, 8'd200}) begin
            failures++;
            $display("FAIL overflow_reject got=%b required=%b", {coin_reject, total}, {1'b1, 8'd200});
        end
        drive(0, 0, 1, 3, 0);
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({change_valid, change_amt} !== {1'b1, 8'd75}) begin
            failures++;
            $display("FAIL overflow_change got=%b required=%b", {change_valid, change_amt}, {1'b1, 8'd75});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(1, 10, 0, 0, 0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (change_valid !== (k == TIMEOUT) || (k == TIMEOUT && change_amt !== 8'd10)) begin
                failures++;
                $display("FAIL timeout_cycle%0d got=%b/%0d required=%b/10", k, change_valid, change_amt,
                         k == TIMEOUT);
            end
        end
        do_reset();
        drive(1, 10, 0, 0, 0);
        for (int k = 1; k < 15; k++) drive(0, 0, 0, 0, 0);
        drive(1, 5, 0, 0, 0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (change_valid !== (k == TIMEOUT) || (k == TIMEOUT && change_amt !== 8'd15)) begin
                failures++;
                $display("FAIL timeout_restart%0d got=%b/%0d required=%b/15", k, change_valid, change_amt,
                         k == TIMEOUT);
            end
        end
    endtask

    task automatic test_priority_combo();
        do_reset();
        drive(1, 60, 0, 0, 0);
        drive(1, 5, 1, 0, 1);
        checks++;
        if ({change_valid, change_amt, coin_reject, disp, sel_err} !== {1'b1, 8'd60, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL combo_cancel got=%b required=%b", {change_valid, change_amt, coin_reject, disp, sel_err},
                     {1'b1, 8'd60, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_reset_mid_dispense();
        do_reset();
        drive(1, 80, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        checks++;
        if (disp !== 1'b1) begin
            failures++;
            $display("FAIL midreset_disp got=%b required=1", disp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({total, disp, disp_sel, change_valid, change_amt, coin_reject, sel_err, busy} !== '0) begin
            failures++;
            $display("FAIL midreset_async got=%h required=0",
                     {total, disp, disp_sel, change_valid, change_amt, coin_reject, sel_err, busy});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if ({change_valid, total} !== '0) begin
                failures++;
                $display("FAIL midreset_nochange%0d got=%b required=0", k, {change_valid, total});
            end
        end
    endtask

    task automatic test_zero_price();
        load_prices(0, 75, 100, 125);
        do_reset();
        drive(0, 0, 1, 0, 0);
        checks++;
        if ({disp, disp_sel, total, sel_err} !== {1'b1, 2'd0, 8'd0, 1'b0}) begin
            failures++;
            $display("FAIL zero_dispense got=%b required=%b", {disp, disp_sel, total, sel_err}, {1'b1, 2'd0, 8'd0, 1'b0});
        end
        drive(0, 0, 1, 1, 0);
        checks++;
        if ({change_valid, busy, sel_err} !== 3'b001) begin
            failures++;
            $display("FAIL zero_nochange got=%b required=001", {change_valid, busy, sel_err});
        end
        load_prices(50, 75, 100, 125);
    endtask

    task automatic test_random();
        int coin_set[7];
        logic [22:0] got;
        logic [22:0] req;
        coin_set = '{0, 5, 10, 25, 50, 100, 200};
        load_prices(15, 40, 90, 160);
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bit quiet;
            bit cv, sv, cn;
            int cval, s;
            quiet = (i % 100) >= 70;
            cv    = !quiet && ($urandom_range(0, 2) == 0);
            cval  = coin_set[$urandom_range(0, 6)];
            sv    = !quiet && ($urandom_range(0, 5) == 0);
            s     = $urandom_range(0, NUM_SEL - 1);
            cn    = !quiet && ($urandom_range(0, 24) == 0);
            drive(cv, cval, sv, s, cn);
            got = {total, disp, disp_sel, change_valid, change_amt, coin_reject, sel_err, busy};
            req = {8'(exp_total), exp_disp, 2'(exp_disp_sel), exp_cv, 8'(exp_amt), exp_cr, exp_se, exp_busy};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h required=%h", i, got, req);
            end
        end
        load_prices(50, 75, 100, 125);
    endtask

    initial begin
        load_prices(50, 75, 100, 125);
        model_reset();
        test_reset();
        test_exact_price();
        test_change();
        test_sel_err_cancel();
        test_overflow();
        test_timeout();
        test_priority_combo();
        test_reset_mid_dispense();
        test_zero_price();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Multi-product soda vending controller with integrated datapath.
- Accumulates coin credit and accepts a product selection from a parameterised price table.
- Dispenses when credit covers the price, then returns change. Handles cancel/refund, an inactivity timeout and credit-overflow coin rejection.
- Sits between the coin acceptor/keypad front end and the dispense/change actuators.

Parameters:
WIDTH, 8, bit width of coin values, prices, credit and change
NUM_SEL, 4, number of products (entries in price table)
SEL_W, 2, width of product select; must satisfy 2^SEL_W >= NUM_SEL
TIMEOUT, 20, idle cycles in COLLECT before automatic refund (>= 2)
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
coin_valid  input  1  one-cycle strobe: coin_val holds an inserted coin
coin_val  input  WIDTH  value of inserted coin
sel_valid  input  1  one-cycle strobe: sel holds a product request
sel  input  SEL_W  requested product index
prices  input  NUM_SEL*WIDTH  flat price table; product i at bits [i*WIDTH +: WIDTH]; quasi-static
cancel  input  1  refund request
total  output  WIDTH  current registered credit
disp  output  1  one-cycle dispense pulse
disp_sel  output  SEL_W  product index being dispensed (valid while disp=1, held otherwise)
change_valid  output  1  one-cycle change/refund pulse
change_amt  output  WIDTH  change value (valid while change_valid=1; 0 otherwise)
coin_reject  output  1  one-cycle pulse: coin of this cycle not credited
sel_err  output  1  one-cycle pulse: selection refused (index >= NUM_SEL or insufficient credit)
busy  output  1  high in DISPENSE and CHANGE

Behaviour:
- All outputs registered. Reset (rst_n low, async) forces: state IDLE, total=0, timeout counter=0, disp=0, disp_sel=0, change_valid=0, change_amt=0, coin_reject=0, sel_err=0, busy=0. Reset mid-transaction discards credit without a refund pulse.
- States:
  - IDLE (total=0)
  - COLLECT
  - DISPENSE
  - CHANGE
- Event priority in IDLE/COLLECT, per cycle: cancel > sel_valid > timeout > coin_valid.
- cancel:
  - COLLECT: go to CHANGE with refund = total.
  - IDLE: no effect.
  - A coin in the same cycle is rejected (coin_reject=1).
- sel_valid:
  - Accepted only if sel < NUM_SEL and total >= prices[sel] (unsigned compare on registered total).
  - On accept: latch sel into disp_sel, total <= total - price, go to DISPENSE.
  - Otherwise: sel_err=1 next cycle and the state is unchanged.
  - A coin in the same cycle is rejected regardless of the selection outcome.
- coin_valid (no higher-priority event):
  - Compute total + coin_val at WIDTH+1 bits.
  - If the carry is set, reject: coin_reject=1, total unchanged.
  - Otherwise total <= sum, timeout counter <= 0, and IDLE goes to COLLECT.
  - coin_val=0 is accepted, restarts the timer and is legal.
- Timeout:
  - The counter increments each COLLECT cycle without an accepted coin.
  - When counter == TIMEOUT-1, go to CHANGE with refund = total; counter clears.
  - The counter is held at 0 outside COLLECT.
- DISPENSE (exactly 1 cycle):
  - disp=1, busy=1.
  - Next state is CHANGE if total > 0, else IDLE.
- CHANGE (exactly 1 cycle):
  - change_valid=1, change_amt=total, busy=1.
  - total <= 0, next state IDLE.
- Inputs during DISPENSE/CHANGE:
  - coin_valid produces coin_reject.
  - sel_valid produces sel_err.
  - cancel is ignored.
- Latency: coin at edge n reflects in total after edge n. Accepted selection at edge n gives disp high for cycle n+1 and change_valid for cycle n+2 if change is due.
- Zero price with zero credit: selection in IDLE dispenses with no change pulse.
- Credit wraps never; saturation is prevented by rejection.

Test Plan:
- WIDTH=8, prices={50,75,100,125}; coins 25,25,25, then sel=1 -> total 25/50/75; disp=1 with disp_sel=1, total=0; no change_valid; back to IDLE.
- Coins 100,50, then sel=0 (price 50) -> disp pulse, then change_valid with change_amt=100, then IDLE, total=0.
- Coin 25, then sel=2 (price 100) -> sel_err pulse, total stays 25, state COLLECT; then cancel -> change_amt=25.
- Coin 200, then coin 100 -> second coin gets coin_reject, total stays 200; sel=3 -> change_amt=75.
- Coin 10, then no activity for TIMEOUT=20 cycles -> change_valid with 10 exactly 20 cycles after the coin; a coin at cycle 15 restarts the count.
- sel_valid, coin_valid and cancel all in one COLLECT cycle with total 60 -> refund 60, coin_reject=1; also assert rst_n low mid-DISPENSE -> all outputs 0 immediately, no change pulse.
